// File: rtl/bcd_count_sequencer_if.sv
// rtl/bcd_count_sequencer_if.sv - control/status bundle between the sequencer and its host and BCD counter
interface bcd_count_sequencer_if #(
  parameter int PRESCALE_W = 8
);
  logic                  start;
  logic                  stop;
  logic                  load_req;
  logic [7:0]            load_val;
  logic                  up_down_in;
  logic [PRESCALE_W-1:0] prescale;
  logic                  wrap_mode;
  logic [3:0]            digit1;
  logic [3:0]            digit0;
  logic                  cnt_en;
  logic                  cnt_up;
  logic                  cnt_load;
  logic [7:0]            cnt_load_val;
  logic                  busy;
  logic                  done;
  logic [1:0]            state;

  modport slave (
    input  start, stop, load_req, load_val, up_down_in, prescale, wrap_mode, digit1, digit0,
    output cnt_en, cnt_up, cnt_load, cnt_load_val, busy, done, state
  );

  modport master (
    output start, stop, load_req, load_val, up_down_in, prescale, wrap_mode, digit1, digit0,
    input  cnt_en, cnt_up, cnt_load, cnt_load_val, busy, done, state
  );
endinterface

// File: rtl/bcd_count_sequencer.sv
// rtl/bcd_count_sequencer.sv - run/halt/preset sequencer driving a two-digit BCD counter
module bcd_count_sequencer #(
  parameter int PRESCALE_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  bcd_count_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    LOAD = 2'b10,
    HALT = 2'b11
  } state_e;

  state_e                state_q, state_d;
  logic                  dir_meta_q, dir_sync_q;
  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic                  cnt_en_q, cnt_en_d;
  logic                  cnt_load_q, cnt_load_d;
  logic                  done_q, done_d;
  logic                  cnt_up_q, cnt_up_d;
  logic [7:0]            load_val_q, load_val_d;
  logic                  tick;
  logic                  terminal;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] nib);
    return (nib > 4'd9) ? 4'd9 : nib;
  endfunction

  // Pad direction is asynchronous; only the second flop is ever consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_meta_q <= 1'b1;
      dir_sync_q <= 1'b1;
    end else begin
      dir_meta_q <= bus.up_down_in;
      dir_sync_q <= dir_meta_q;
    end
  end

  assign tick     = (state_q == RUN) && (pre_cnt_q >= bus.prescale);
  assign terminal = ( cnt_up_q && (bus.digit1 == 4'd9) && (bus.digit0 == 4'd9)) ||
                    (!cnt_up_q && (bus.digit1 == 4'd0) && (bus.digit0 == 4'd0));

  always_comb begin
    state_d    = state_q;
    cnt_en_d   = 1'b0;
    cnt_load_d = 1'b0;
    done_d     = 1'b0;
    load_val_d = load_val_q;

    // LOAD always falls back to IDLE, which makes a held load_req alternate.
    if (state_q == LOAD) begin
      state_d = IDLE;
    end else if (bus.load_req) begin
      state_d    = LOAD;
      cnt_load_d = 1'b1;
      load_val_d = {clamp_bcd(bus.load_val[7:4]), clamp_bcd(bus.load_val[3:0])};
    end else if (state_q == RUN) begin
      if (bus.stop) begin
        state_d = IDLE;
      end else if (tick) begin
        if (terminal && !bus.wrap_mode) begin
          state_d = HALT;
          done_d  = 1'b1;
        end else begin
          cnt_en_d = 1'b1;
        end
      end
    end else if (!bus.stop && bus.start) begin
      state_d = RUN;
    end
  end

  always_comb begin
    pre_cnt_d = '0;
    if ((state_q == RUN) && (state_d == RUN) && !tick) begin
      pre_cnt_d = pre_cnt_q + {{(PRESCALE_W-1){1'b0}}, 1'b1};
    end
  end

  // Direction is frozen between ticks so a step never sees a mid-period flip.
  always_comb begin
    cnt_up_d = cnt_up_q;
    if ((state_q != RUN) || tick) begin
      cnt_up_d = dir_sync_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pre_cnt_q  <= '0;
      cnt_en_q   <= 1'b0;
      cnt_load_q <= 1'b0;
      done_q     <= 1'b0;
      cnt_up_q   <= 1'b1;
      load_val_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      cnt_en_q   <= cnt_en_d;
      cnt_load_q <= cnt_load_d;
      done_q     <= done_d;
      cnt_up_q   <= cnt_up_d;
      load_val_q <= load_val_d;
    end
  end

  assign bus.cnt_en       = cnt_en_q;
  assign bus.cnt_up       = cnt_up_q;
  assign bus.cnt_load     = cnt_load_q;
  assign bus.cnt_load_val = load_val_q;
  assign bus.busy         = (state_q == RUN);
  assign bus.done         = done_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_bcd_count_sequencer.sv
// tb/tb_bcd_count_sequencer.sv - directed self-checking bench for bcd_count_sequencer
module tb_bcd_count_sequencer;
  localparam int PW = 8;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  bcd_count_sequencer_if #(.PRESCALE_W(PW)) bus ();

  bcd_count_sequencer #(.PRESCALE_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " state"}, 32'(bus.state), 32'h0);
    check({tag, " cnt_en"}, 32'(bus.cnt_en), 32'h0);
    check({tag, " cnt_load"}, 32'(bus.cnt_load), 32'h0);
    check({tag, " done"}, 32'(bus.done), 32'h0);
    check({tag, " busy"}, 32'(bus.busy), 32'h0);
    check({tag, " cnt_up"}, 32'(bus.cnt_up), 32'h1);
    check({tag, " load_val"}, 32'(bus.cnt_load_val), 32'h00);
  endtask

  logic prev_up;
  int   changed_at;
  logic en_at_change;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.load_req = 1'b0;
    bus.load_val = 8'h00;
    bus.up_down_in = 1'b1;
    bus.prescale = 8'd3;
    bus.wrap_mode = 1'b1;
    bus.digit1 = 4'd0;
    bus.digit0 = 4'd0;
    step();
    step();
    check_reset_values("reset");
    rst = 1'b0;

    // start+stop together in IDLE stays IDLE; in RUN goes IDLE
    bus.start = 1'b1; bus.stop = 1'b1;
    step();
    check("both_idle state", 32'(bus.state), 32'h0);
    bus.stop = 1'b0;
    step();
    check("start_run state", 32'(bus.state), 32'h1);
    bus.stop = 1'b1;
    step();
    check("both_run state", 32'(bus.state), 32'h0);
    bus.start = 1'b0; bus.stop = 1'b0;
    step();

    // prescale=3 cadence
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("run busy", 32'(bus.busy), 32'h1);
    check("run entry cnt_en", 32'(bus.cnt_en), 32'h0);
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("cadence cnt_en c%0d", i), 32'(bus.cnt_en), (i % 4 == 0) ? 32'h1 : 32'h0);
    end

    // terminal up with wrap off -> HALT
    bus.wrap_mode = 1'b0;
    bus.digit1 = 4'd9; bus.digit0 = 4'd9;
    step(); step(); step(); step();
    check("halt cnt_en", 32'(bus.cnt_en), 32'h0);
    check("halt done", 32'(bus.done), 32'h1);
    check("halt state", 32'(bus.state), 32'h3);
    bus.up_down_in = 1'b0;
    step();
    check("halt done pulse", 32'(bus.done), 32'h0);
    check("halt state hold", 32'(bus.state), 32'h3);
    step(); step(); step();
    check("halt cnt_up follows", 32'(bus.cnt_up), 32'h0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("restart state", 32'(bus.state), 32'h1);

    // terminal down with wrap on -> keeps counting
    bus.wrap_mode = 1'b1;
    bus.digit1 = 4'd0; bus.digit0 = 4'd0;
    step(); step(); step(); step();
    check("wrap cnt_en", 32'(bus.cnt_en), 32'h1);
    check("wrap done", 32'(bus.done), 32'h0);
    check("wrap state", 32'(bus.state), 32'h1);

    // preset during RUN with clamp
    bus.load_req = 1'b1; bus.load_val = 8'hA7;
    step();
    bus.load_req = 1'b0;
    check("load state", 32'(bus.state), 32'h2);
    check("load strobe", 32'(bus.cnt_load), 32'h1);
    check("load value", 32'(bus.cnt_load_val), 32'h97);
    check("load cnt_en", 32'(bus.cnt_en), 32'h0);
    step();
    check("post load state", 32'(bus.state), 32'h0);
    check("post load strobe", 32'(bus.cnt_load), 32'h0);
    check("post load hold", 32'(bus.cnt_load_val), 32'h97);

    // held load_req alternates LOAD/IDLE
    bus.load_req = 1'b1; bus.load_val = 8'h3F;
    step();
    check("held c1 state", 32'(bus.state), 32'h2);
    check("held c1 value", 32'(bus.cnt_load_val), 32'h39);
    step();
    check("held c2 state", 32'(bus.state), 32'h0);
    step();
    check("held c3 state", 32'(bus.state), 32'h2);
    bus.load_req = 1'b0;
    step();

    // direction change only on a tick, prescale=7
    bus.prescale = 8'd7;
    bus.up_down_in = 1'b1;
    bus.digit1 = 4'd5; bus.digit0 = 4'd5;
    step(); step(); step(); step();
    check("dir pre cnt_up", 32'(bus.cnt_up), 32'h1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step(); step();
    bus.up_down_in = 1'b0;
    prev_up = bus.cnt_up;
    changed_at = -1;
    en_at_change = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (bus.cnt_up !== prev_up && changed_at < 0) begin
        changed_at = i;
        en_at_change = bus.cnt_en;
      end
      prev_up = bus.cnt_up;
    end
    check("dir change cycle", 32'(changed_at), 32'd6);
    check("dir change on tick", 32'(en_at_change), 32'h1);
    check("dir new value", 32'(bus.cnt_up), 32'h0);

    // reset one cycle before the next tick
    bus.load_val = 8'h00;
    for (int i = 0; i < 6; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_values("mid-run reset");
    step();
    check("after reset cnt_en", 32'(bus.cnt_en), 32'h0);
    check("after reset state", 32'(bus.state), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
